// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART definitions: frame width, receiver FSM encodings and
// the helpers for the baud divider and the three-sample majority voter.
package uart_rx_oversampled_pkg;

    localparam int FrameWidth = 8;

    typedef logic [FrameWidth-1:0] frameByte_t;

    localparam logic [1:0] StateIdle  = 2'd0;
    localparam logic [1:0] StateStart = 2'd1;
    localparam logic [1:0] StateData  = 2'd2;
    localparam logic [1:0] StateStop  = 2'd3;

    // Clocks per oversample tick, integer floor.
    function automatic int tickDivide(input int clockFreq, input int baudRate, input int oversample);
        return clockFreq / (baudRate * oversample);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Ready/valid byte stream from the UART receiver, with its two error pulses.
interface uart_rx_oversampled_if;
    import uart_rx_oversampled_pkg::*;

    frameByte_t DataOut;
    logic       DataOutValid;
    logic       DataOutReady;
    logic       FrameError;
    logic       Overrun;

    modport master (
        output DataOut,
        output DataOutValid,
        output FrameError,
        output Overrun,
        input  DataOutReady
    );

    modport slave (
        input  DataOut,
        input  DataOutValid,
        input  FrameError,
        input  Overrun,
        output DataOutReady
    );

endinterface

// File: rtl/uart_rx_oversampled_baud_tick.sv
// Oversample tick divider: one-cycle Tick every TickDiv clocks.
// Clear holds the count at zero so the first tick lands TickDiv clocks
// after Clear drops, aligning the sample phase to the start-bit edge.
module uart_rx_oversampled_baud_tick #(
    parameter int TickDiv = 27
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    output logic Tick
);

    localparam int CountWidth = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(TickDiv - 1);

    logic [CountWidth-1:0] count;

    assign Tick = !Clear && (count == LastCount);

    // Free-running 0..TickDiv-1 counter, held at zero while cleared.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (Clear || (count == LastCount)) begin
            count <= '0;
        end else begin
            count <= count + CountWidth'(1);
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling 8N1 UART receiver with ready/valid output buffer.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   StateIdle  | line idle; waiting for a low level on the synced input
//   StateStart | inside start bit; mid vote confirms it or rejects glitch
//   StateData  | one vote per data bit, shifted in LSB first
//   StateStop  | mid vote on stop bit: load byte, overrun or frame error
//
// Each bit is decided by one majority vote over the samples at labels
// Mid-1, Mid and Mid+1; the vote is final on the Mid+1 tick, so all state
// changes happen there. Returning to idle at the stop-bit vote leaves the
// rest of the stop bit as margin for the next start edge.
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int ClockFreq  = 50_000_000,
    parameter int BaudRate   = 115_200,
    parameter int Oversample = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      SIn,
    uart_rx_oversampled_if.master     rxPort
);

    localparam int TickDiv     = tickDivide(ClockFreq, BaudRate, Oversample);
    localparam int SampleWidth = $clog2(Oversample);
    localparam int IndexWidth  = $clog2(FrameWidth);
    localparam int Mid         = Oversample / 2;

    localparam logic [SampleWidth-1:0] LastLabel   = SampleWidth'(Oversample - 1);
    localparam logic [SampleWidth-1:0] LabelBefore = SampleWidth'(Mid - 1);
    localparam logic [SampleWidth-1:0] LabelMid    = SampleWidth'(Mid);
    localparam logic [SampleWidth-1:0] LabelAfter  = SampleWidth'(Mid + 1);
    localparam logic [IndexWidth-1:0]  LastIndex   = IndexWidth'(FrameWidth - 1);

    logic                   resetMeta;
    logic                   resetSync;
    logic                   syncMeta;
    logic                   syncIn;
    logic [1:0]             state;
    logic [SampleWidth-1:0] sampleCnt;
    logic [SampleWidth-1:0] tickLabel;
    logic [IndexWidth-1:0]  bitIndex;
    frameByte_t             shiftReg;
    logic                   sampleA;
    logic                   sampleB;
    logic                   vote;
    logic                   voteNow;
    logic                   tick;
    logic                   tickClear;
    logic                   lineArmed;
    logic                   loadByte;
    logic                   overrunNow;
    logic                   frameErrNow;

    // Reset asserts asynchronously and releases two clocks later, in step with Clock.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            resetMeta <= 1'b1;
            resetSync <= 1'b1;
        end else begin
            resetMeta <= 1'b0;
            resetSync <= resetMeta;
        end
    end

    // Two-flop synchronizer for the asynchronous serial line, idle high.
    always_ff @(posedge Clock or posedge resetSync) begin
        if (resetSync) begin
            syncMeta <= 1'b1;
            syncIn   <= 1'b1;
        end else begin
            syncMeta <= SIn;
            syncIn   <= syncMeta;
        end
    end

    assign tickClear = (state == StateIdle);

    uart_rx_oversampled_baud_tick #(
        .TickDiv (TickDiv)
    ) baudTick (
        .Clock (Clock),
        .Reset (resetSync),
        .Clear (tickClear),
        .Tick  (tick)
    );

    // Label of the tick now occurring: ticks elapsed since the bit began, modulo Oversample.
    assign tickLabel   = (sampleCnt == LastLabel) ? '0 : sampleCnt + SampleWidth'(1);
    assign voteNow     = tick && (tickLabel == LabelAfter);
    assign vote        = majority3(sampleA, sampleB, syncIn);

    assign loadByte    = (state == StateStop) && voteNow && vote &&
                         (!rxPort.DataOutValid || rxPort.DataOutReady);
    assign overrunNow  = (state == StateStop) && voteNow && vote &&
                         rxPort.DataOutValid && !rxPort.DataOutReady;
    assign frameErrNow = (state == StateStop) && voteNow && !vote;

    // Per-bit tick counter, restarted at every start edge.
    always_ff @(posedge Clock or posedge resetSync) begin
        if (resetSync) begin
            sampleCnt <= '0;
        end else if (state == StateIdle) begin
            sampleCnt <= '0;
        end else if (tick) begin
            sampleCnt <= tickLabel;
        end
    end

    // Hold the two earlier samples of the vote; the third is the live synced input.
    always_ff @(posedge Clock or posedge resetSync) begin
        if (resetSync) begin
            sampleA <= 1'b1;
            sampleB <= 1'b1;
        end else if (tick) begin
            if (tickLabel == LabelBefore) sampleA <= syncIn;
            if (tickLabel == LabelMid)    sampleB <= syncIn;
        end
    end

    // After a frame error the line is still low; wait for it to go high before re-arming.
    always_ff @(posedge Clock or posedge resetSync) begin
        if (resetSync) begin
            lineArmed <= 1'b0;
        end else if (frameErrNow) begin
            lineArmed <= 1'b0;
        end else if ((state == StateIdle) && syncIn) begin
            lineArmed <= 1'b1;
        end
    end

    // Frame FSM with bit index and LSB-first shift register.
    always_ff @(posedge Clock or posedge resetSync) begin
        if (resetSync) begin
            state    <= StateIdle;
            bitIndex <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                StateIdle: begin
                    if (!syncIn && lineArmed) begin
                        state    <= StateStart;
                        bitIndex <= '0;
                    end
                end
                StateStart: begin
                    if (voteNow) begin
                        state    <= vote ? StateIdle : StateData;
                        bitIndex <= '0;
                    end
                end
                StateData: begin
                    if (voteNow) begin
                        shiftReg <= {vote, shiftReg[FrameWidth-1:1]};
                        if (bitIndex == LastIndex) begin
                            state <= StateStop;
                        end else begin
                            bitIndex <= bitIndex + IndexWidth'(1);
                        end
                    end
                end
                StateStop: begin
                    if (voteNow) begin
                        state <= StateIdle;
                    end
                end
                default: state <= StateIdle;
            endcase
        end
    end

    // Single-entry output buffer; a load in the accept cycle keeps Valid high.
    always_ff @(posedge Clock or posedge resetSync) begin
        if (resetSync) begin
            rxPort.DataOut      <= '0;
            rxPort.DataOutValid <= 1'b0;
        end else if (loadByte) begin
            rxPort.DataOut      <= shiftReg;
            rxPort.DataOutValid <= 1'b1;
        end else if (rxPort.DataOutValid && rxPort.DataOutReady) begin
            rxPort.DataOutValid <= 1'b0;
        end
    end

    // Error pulses, one cycle each; the stop vote value makes them exclusive.
    always_ff @(posedge Clock or posedge resetSync) begin
        if (resetSync) begin
            rxPort.FrameError <= 1'b0;
            rxPort.Overrun    <= 1'b0;
        end else begin
            rxPort.FrameError <= frameErrNow;
            rxPort.Overrun    <= overrunNow;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: bytes sent are queued as
// expectations and popped when the receiver hands a byte over.
module tb_uart_rx_oversampled;

    localparam int TickDiv    = 27;
    localparam int Oversample = 16;
    localparam int BitClocks  = TickDiv * Oversample;
    localparam int FastBit    = 423;
    localparam int SlowBit    = 441;
    // Stop-bit vote completes on the Mid+1 sample; allow sync and register delay.
    localparam int LatencyMin = (Oversample / 2) * TickDiv;
    localparam int LatencyMax = (Oversample / 2 + 1) * TickDiv + 5;

    logic Clock;
    logic Reset;
    logic SIn;

    uart_rx_oversampled_if rxBus ();

    uart_rx_oversampled #(
        .ClockFreq  (50_000_000),
        .BaudRate   (115_200),
        .Oversample (Oversample)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .SIn    (SIn),
        .rxPort (rxBus)
    );

    int checkCount = 0;
    int errorCount = 0;
    int cycleCount = 0;
    int validRises = 0;
    int validHighCycles = 0;
    int lastRiseCycle = 0;
    int stopStartCycle = 0;
    int frameErrCount = 0;
    int overrunCount = 0;
    int bothFlags = 0;
    logic prevValid = 1'b0;
    logic [7:0] expectQ [$];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cycleCount <= cycleCount + 1;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Output monitor and scoreboard, sampled mid-cycle.
    always @(negedge Clock) begin
        logic [7:0] expByte;
        if (rxBus.DataOutValid && !prevValid) begin
            validRises++;
            lastRiseCycle = cycleCount;
        end
        if (rxBus.DataOutValid) validHighCycles++;
        if (rxBus.FrameError) frameErrCount++;
        if (rxBus.Overrun) overrunCount++;
        if (rxBus.FrameError && rxBus.Overrun) bothFlags++;
        if (rxBus.DataOutValid && rxBus.DataOutReady) begin
            if (expectQ.size() == 0) begin
                checkValue("spuriousByte", expectQ.size(), 1);
            end else begin
                expByte = expectQ.pop_front();
                checkValue("rxByte", rxBus.DataOut, expByte);
            end
        end
        prevValid = rxBus.DataOutValid;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Drives start, 8 data bits LSB first, stop. abortBit >= 0 stops half way through that frame bit.
    task automatic sendFrame(input logic [7:0] value, input logic stopBit, input int bitLen, input int abortBit);
        logic [9:0] frame;
        frame = {stopBit, value, 1'b0};
        for (int b = 0; b < 10; b++) begin
            SIn = frame[b];
            if (b == 9) stopStartCycle = cycleCount;
            if (b == abortBit) begin
                waitCycles(bitLen / 2);
                return;
            end
            waitCycles(bitLen);
        end
        SIn = 1'b1;
    endtask

    initial begin
        int rises0;
        int high0;
        int fe0;
        int ov0;
        int latency;

        Reset = 1'b1;
        SIn = 1'b1;
        rxBus.DataOutReady = 1'b1;
        waitCycles(5);
        checkValue("resetDataOut", rxBus.DataOut, 0);
        checkValue("resetValid", rxBus.DataOutValid, 0);
        checkValue("resetFrameError", rxBus.FrameError, 0);
        checkValue("resetOverrun", rxBus.Overrun, 0);
        Reset = 1'b0;
        waitCycles(20);

        // 1: single frame 0xA5, consumer ready
        rises0 = validRises; high0 = validHighCycles; fe0 = frameErrCount; ov0 = overrunCount;
        expectQ.push_back(8'hA5);
        sendFrame(8'hA5, 1'b1, BitClocks, -1);
        waitCycles(BitClocks);
        latency = lastRiseCycle - stopStartCycle;
        checkValue("validLatencyWindow", (latency >= LatencyMin) && (latency <= LatencyMax), 1);
        checkValue("validRisesA5", validRises - rises0, 1);
        checkValue("validOneCycle", validHighCycles - high0, 1);
        checkValue("flagsA5", (frameErrCount - fe0) + (overrunCount - ov0), 0);

        // 2: 100-clock glitch is rejected
        rises0 = validRises; fe0 = frameErrCount; ov0 = overrunCount;
        SIn = 1'b0;
        waitCycles(100);
        SIn = 1'b1;
        waitCycles(2 * BitClocks);
        checkValue("glitchNoValid", validRises - rises0, 0);
        checkValue("glitchNoFlags", (frameErrCount - fe0) + (overrunCount - ov0), 0);

        // 3: frame error on 0x3C, then 0x55 received
        rises0 = validRises; fe0 = frameErrCount; ov0 = overrunCount;
        sendFrame(8'h3C, 1'b0, BitClocks, -1);
        SIn = 1'b1;
        waitCycles(BitClocks);
        checkValue("frameErrorPulse", frameErrCount - fe0, 1);
        checkValue("frameErrorNoValid", validRises - rises0, 0);
        checkValue("frameErrorNoOverrun", overrunCount - ov0, 0);
        expectQ.push_back(8'h55);
        sendFrame(8'h55, 1'b1, BitClocks, -1);
        waitCycles(BitClocks);
        checkValue("after3CValid", validRises - rises0, 1);
        checkValue("queueDrained3", expectQ.size(), 0);

        // 4: consumer stalled, second frame overruns
        rises0 = validRises; fe0 = frameErrCount; ov0 = overrunCount;
        rxBus.DataOutReady = 1'b0;
        expectQ.push_back(8'h11);
        sendFrame(8'h11, 1'b1, BitClocks, -1);
        sendFrame(8'h22, 1'b1, BitClocks, -1);
        checkValue("overrunPulse", overrunCount - ov0, 1);
        checkValue("overrunNoFrameError", frameErrCount - fe0, 0);
        checkValue("overrunHeldValid", rxBus.DataOutValid, 1);
        checkValue("overrunKeptByte", rxBus.DataOut, 8'h11);
        waitCycles(BitClocks);
        rxBus.DataOutReady = 1'b1;
        waitCycles(10);
        checkValue("overrunOneByte", validRises - rises0, 1);
        checkValue("queueDrained4", expectQ.size(), 0);
        checkValue("overrunValidCleared", rxBus.DataOutValid, 0);

        // 5: reset in the middle of data bit 4 while a byte is buffered
        rxBus.DataOutReady = 1'b0;
        sendFrame(8'h7E, 1'b1, BitClocks, -1);
        checkValue("bufferedBeforeReset", rxBus.DataOutValid, 1);
        sendFrame(8'hC3, 1'b1, BitClocks, 5);
        Reset = 1'b1;
        #1;
        checkValue("midResetDataOut", rxBus.DataOut, 0);
        checkValue("midResetValid", rxBus.DataOutValid, 0);
        checkValue("midResetFrameError", rxBus.FrameError, 0);
        checkValue("midResetOverrun", rxBus.Overrun, 0);
        SIn = 1'b1;
        rxBus.DataOutReady = 1'b1;
        waitCycles(10);
        Reset = 1'b0;
        waitCycles(BitClocks);
        rises0 = validRises; fe0 = frameErrCount; ov0 = overrunCount;
        expectQ.push_back(8'hC3);
        sendFrame(8'hC3, 1'b1, BitClocks, -1);
        waitCycles(BitClocks);
        checkValue("afterResetValid", validRises - rises0, 1);
        checkValue("afterResetFlags", (frameErrCount - fe0) + (overrunCount - ov0), 0);
        checkValue("queueDrained5", expectQ.size(), 0);

        // 6: ten back-to-back frames at +2% then -2% baud
        rises0 = validRises; fe0 = frameErrCount; ov0 = overrunCount;
        for (int i = 0; i < 10; i++) begin
            expectQ.push_back(8'(i));
            sendFrame(8'(i), 1'b1, FastBit, -1);
        end
        for (int i = 0; i < 10; i++) begin
            expectQ.push_back(8'(i));
            sendFrame(8'(i), 1'b1, SlowBit, -1);
        end
        waitCycles(BitClocks);
        checkValue("burstCount", validRises - rises0, 20);
        checkValue("burstFlags", (frameErrCount - fe0) + (overrunCount - ov0), 0);
        checkValue("queueDrained6", expectQ.size(), 0);

        checkValue("flagsExclusive", bothFlags, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
